exc_redirect: RTL and testbench
===============================

Name: exc_redirect

Overview:
- Consumes the commit-stage exception and ERET decisions and turns them into a pipeline flush and a fetch redirect.
- Target PC is the exception vector or the CP0 EPC.
- Blocks new instruction-side AXI read requests and discards stale read responses still in flight.
- Redirects fetch only once the instruction bus has drained.
- Sits between the commit stage and the fetch/PC-generation unit.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- CNT_W, 2, width of the outstanding instruction-read counter; maximum outstanding is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- exc_oc  in  1  exception or interrupt taken at commit this cycle.
- eret  in  1  ERET commits this cycle.
- cp0_epc  in  32  current EPC from CP0, used as the ERET target.
- fetch_req_fire  in  1  instruction AR handshake completed this cycle.
- fetch_resp_fire  in  1  instruction R beat with last completed this cycle.
- redirect_ready  in  1  fetch unit accepts the redirect this cycle.
- flush  out  1  one-cycle pulse; kills all pipeline stages younger than commit.
- fetch_hold  out  1  fetch must not issue AR while high.
- drop_resp  out  1  current instruction response is stale and must not enter the pipeline.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch PC.
- busy  out  1  state is not IDLE.
- cnt_err  out  1  sticky error: counter overflow or underflow.

Behaviour:
- Reset values: state IDLE, outstanding=0, all outputs 0, redirect_pc=0. Reset mid-operation returns to IDLE immediately, with no flush and no redirect.
- Outstanding counter (runs in every state):
  - next = cnt + fetch_req_fire - fetch_resp_fire; simultaneous req and resp leave it unchanged.
  - Increment at max saturates and sets cnt_err.
  - Decrement at 0 holds 0 and sets cnt_err.
  - cnt_err clears only on reset.
- States: IDLE, FLUSH, DRAIN, REDIRECT.
- IDLE:
  - Outputs low.
  - exc_oc=1: latch target EXC_VECTOR, go to FLUSH.
  - else eret=1: latch target cp0_epc, sampled this cycle, go to FLUSH.
  - exc_oc has priority over a simultaneous eret.
- FLUSH (exactly 1 cycle):
  - flush=1, fetch_hold=1, drop_resp=fetch_resp_fire.
  - Next state DRAIN if next outstanding != 0, else REDIRECT.
- DRAIN:
  - fetch_hold=1, drop_resp=fetch_resp_fire.
  - Every response in this state is stale.
  - Go to REDIRECT in the cycle after next outstanding reaches 0.
- REDIRECT:
  - fetch_hold=0, redirect_valid=1, redirect_pc=latched target.
  - Held stable until redirect_ready=1, then IDLE.
  - A redirect_ready pulse is not required to arrive in the first REDIRECT cycle.
- Latency:
  - Event in IDLE at cycle N → flush at N+1.
  - With 0 outstanding, redirect_valid at N+2.
  - With k outstanding, redirect_valid appears 1 cycle after the k-th stale response.
- Events in non-IDLE states:
  - exc_oc and eret are ignored; the pipeline is being flushed, so none are legal.
  - The latched target is never overwritten.
- A fetch_req_fire in the event cycle (IDLE) is counted and later drained as stale.
- fetch_req_fire while fetch_hold=1 is a fetch bug. It is still counted, so the counter stays consistent.
- busy = (state != IDLE).
- All outputs are registered except drop_resp, which is combinational from state and fetch_resp_fire.

Test Plan:
- Reset with exc_oc=1 held: all outputs 0 while reset=1 → after release, flush pulse next cycle, then redirect_pc=32'hBFC00380.
- exc_oc with 0 outstanding at cycle 10 → flush=1 at 11, redirect_valid=1 with pc=32'hBFC00380 at 12; redirect_ready at 14 → busy=0 at 15.
- eret with cp0_epc=32'hBFC01234 and 2 outstanding; responses at cycles +3 and +5:
  - drop_resp=1 exactly on both responses.
  - fetch_hold=1 throughout.
  - redirect_valid rises the cycle after the second response, with pc=32'hBFC01234.
- exc_oc and eret together, cp0_epc=32'h80000100 → redirect_pc=32'hBFC00380.
- In the event cycle, fetch_req_fire and fetch_resp_fire both fire with cnt=1:
  - Count stays 1.
  - One stale response is dropped in DRAIN.
  - Then REDIRECT.
- Error and mid-operation reset:
  - fetch_resp_fire with cnt=0 → cnt_err=1 and sticky.
  - 3 reqs with CNT_W=2, then a 4th → saturate at 3, cnt_err=1.
  - Reset asserted during DRAIN → IDLE, cnt_err=0, no redirect issued.

Source files
------------

// File: rtl/exc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : exc_redirect
//  Description : Turns commit-stage exception / ERET decisions into a single
//                pipeline flush and a fetch redirect. The redirect is released
//                only after every in-flight instruction read has come back,
//                and those stale responses are marked for discard.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_redirect #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          CNT_W      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_oc,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  input  logic        fetch_req_fire,
  input  logic        fetch_resp_fire,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        fetch_hold,
  output logic        drop_resp,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        cnt_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_err_q, cnt_err_d;
  logic [31:0]      target_q, target_d;

  logic             flush_q, flush_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             busy_q, busy_d;

  // Outstanding instruction-read tracking; saturates at both ends and flags misuse.
  always_comb begin
    cnt_d     = cnt_q;
    cnt_err_d = cnt_err_q;
    if (fetch_req_fire && !fetch_resp_fire) begin
      if (cnt_q == CNT_MAX) begin
        cnt_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!fetch_req_fire && fetch_resp_fire) begin
      if (cnt_q == CNT_ZERO) begin
        cnt_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Next-state logic; the target is captured only when leaving IDLE so it
  // can never be overwritten by a late event while a redirect is pending.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_oc) begin
          target_d = EXC_VECTOR;
          state_d  = ST_FLUSH;
        end else if (eret) begin
          target_d = cp0_epc;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Decision uses the post-update count so a response in this cycle counts.
        state_d = (cnt_d != CNT_ZERO) ? ST_DRAIN : ST_REDIRECT;
      end
      ST_DRAIN: begin
        if (cnt_d == CNT_ZERO) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    flush_d          = (state_d == ST_FLUSH);
    fetch_hold_d     = (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
    redirect_valid_d = (state_d == ST_REDIRECT);
    redirect_pc_d    = (state_d == ST_REDIRECT) ? target_d : 32'h0000_0000;
    busy_d           = (state_d != ST_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= CNT_ZERO;
      cnt_err_q        <= 1'b0;
      target_q         <= 32'h0000_0000;
      flush_q          <= 1'b0;
      fetch_hold_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0000_0000;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cnt_err_q        <= cnt_err_d;
      target_q         <= target_d;
      flush_q          <= flush_d;
      fetch_hold_q     <= fetch_hold_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  // Any response seen while flushing or draining belongs to the killed path.
  assign drop_resp = fetch_resp_fire && ((state_q == ST_FLUSH) || (state_q == ST_DRAIN));

  assign flush          = flush_q;
  assign fetch_hold     = fetch_hold_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;
  assign cnt_err        = cnt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_redirect
//  Description : Scoreboard bench for exc_redirect. Stimulus queues the
//                expected flush / drop / redirect events with their cycle
//                numbers; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_redirect;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_oc;
  logic        eret;
  logic [31:0] cp0_epc;
  logic        fetch_req_fire;
  logic        fetch_resp_fire;
  logic        redirect_ready;
  logic        flush;
  logic        fetch_hold;
  logic        drop_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        cnt_err;

  exc_redirect #(
    .EXC_VECTOR (EXC_VEC),
    .CNT_W      (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .exc_oc          (exc_oc),
    .eret            (eret),
    .cp0_epc         (cp0_epc),
    .fetch_req_fire  (fetch_req_fire),
    .fetch_resp_fire (fetch_resp_fire),
    .redirect_ready  (redirect_ready),
    .flush           (flush),
    .fetch_hold      (fetch_hold),
    .drop_resp       (drop_resp),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy),
    .cnt_err         (cnt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          at;
    logic [31:0] pc;
  } redir_t;

  int     exp_flush[$];
  int     exp_drop[$];
  redir_t exp_redir[$];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event seen at cycle %0d, none required", nm, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic        rv_prev = 1'b0;
  logic [31:0] held_pc = 32'h0;
  always @(negedge clk) begin
    if (flush) begin
      if (exp_flush.size() == 0) unexpected("flush");
      else chk32("flush_cycle", 32'(cyc), 32'(exp_flush.pop_front()));
    end
    if (drop_resp) begin
      if (exp_drop.size() == 0) unexpected("drop_resp");
      else chk32("drop_cycle", 32'(cyc), 32'(exp_drop.pop_front()));
    end
    if (redirect_valid && !rv_prev) begin
      if (exp_redir.size() == 0) begin
        unexpected("redirect");
      end else begin
        redir_t r;
        r = exp_redir.pop_front();
        chk32("redirect_cycle", 32'(cyc), 32'(r.at));
        chk32("redirect_pc", redirect_pc, r.pc);
      end
      held_pc = redirect_pc;
    end else if (redirect_valid && rv_prev) begin
      chk32("redirect_pc_stable", redirect_pc, held_pc);
    end
    rv_prev = redirect_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
  endtask

  int c;

  initial begin
    reset = 1'b1; exc_oc = 1'b1; eret = 1'b0; cp0_epc = 32'h0;
    fetch_req_fire = 1'b0; fetch_resp_fire = 1'b0; redirect_ready = 1'b0;
    repeat (3) tick();
    chk1 ("rst_flush", flush, 1'b0);
    chk1 ("rst_hold", fetch_hold, 1'b0);
    chk1 ("rst_rv", redirect_valid, 1'b0);
    chk32("rst_pc", redirect_pc, 32'h0);
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_err", cnt_err, 1'b0);
    chk1 ("rst_drop", drop_resp, 1'b0);

    // Release reset with exc_oc held; it stays high into FLUSH and is ignored there.
    reset = 1'b0;
    c = cyc;
    exp_flush.push_back(c + 1);
    exp_redir.push_back('{c + 2, EXC_VEC});
    tick();
    chk1("a_busy", busy, 1'b1);
    chk1("a_hold", fetch_hold, 1'b1);
    tick();
    exc_oc = 1'b0;
    chk1("a_hold_redirect", fetch_hold, 1'b0);
    handshake();
    chk1("a_idle", busy, 1'b0);

    // Exception with nothing outstanding; ready arrives late.
    repeat (3) tick();
    exc_oc = 1'b1;
    c = cyc;
    exp_flush.push_back(c + 1);
    exp_redir.push_back('{c + 2, EXC_VEC});
    tick();
    exc_oc = 1'b0;
    tick();
    tick();
    chk1("b_rv_held", redirect_valid, 1'b1);
    chk1("b_busy_held", busy, 1'b1);
    tick();
    handshake();
    chk1("b_idle", busy, 1'b0);
    chk1("b_rv_off", redirect_valid, 1'b0);

    // ERET with two reads outstanding; EPC changes after the event.
    tick();
    fetch_req_fire = 1'b1;
    tick();
    tick();
    fetch_req_fire = 1'b0;
    eret = 1'b1;
    cp0_epc = 32'hBFC01234;
    c = cyc;
    exp_flush.push_back(c + 1);
    tick();
    eret = 1'b0;
    cp0_epc = 32'hDEAD0000;
    chk1("c_hold1", fetch_hold, 1'b1);
    tick();
    chk1("c_hold2", fetch_hold, 1'b1);
    tick();
    fetch_resp_fire = 1'b1;
    exp_drop.push_back(c + 3);
    tick();
    fetch_resp_fire = 1'b0;
    chk1("c_hold4", fetch_hold, 1'b1);
    chk1("c_rv_wait", redirect_valid, 1'b0);
    tick();
    fetch_resp_fire = 1'b1;
    exp_drop.push_back(c + 5);
    exp_redir.push_back('{c + 6, 32'hBFC01234});
    tick();
    fetch_resp_fire = 1'b0;
    chk1("c_hold_release", fetch_hold, 1'b0);
    handshake();
    chk1("c_idle", busy, 1'b0);

    // Simultaneous exception and ERET: exception vector wins.
    tick();
    exc_oc = 1'b1;
    eret = 1'b1;
    cp0_epc = 32'h80000100;
    c = cyc;
    exp_flush.push_back(c + 1);
    exp_redir.push_back('{c + 2, EXC_VEC});
    tick();
    exc_oc = 1'b0;
    eret = 1'b0;
    tick();
    handshake();

    // Event cycle with req and resp together at count 1: count stays 1.
    tick();
    fetch_req_fire = 1'b1;
    tick();
    fetch_req_fire = 1'b0;
    tick();
    exc_oc = 1'b1;
    fetch_req_fire = 1'b1;
    fetch_resp_fire = 1'b1;
    c = cyc;
    exp_flush.push_back(c + 1);
    tick();
    exc_oc = 1'b0;
    fetch_req_fire = 1'b0;
    fetch_resp_fire = 1'b0;
    tick();
    fetch_resp_fire = 1'b1;
    exp_drop.push_back(c + 2);
    exp_redir.push_back('{c + 3, EXC_VEC});
    tick();
    fetch_resp_fire = 1'b0;
    handshake();
    chk1("e_err_clean", cnt_err, 1'b0);

    // Underflow sets a sticky error.
    tick();
    fetch_resp_fire = 1'b1;
    tick();
    fetch_resp_fire = 1'b0;
    chk1("f_underflow_err", cnt_err, 1'b1);
    repeat (3) tick();
    chk1("f_err_sticky", cnt_err, 1'b1);
    reset = 1'b1;
    tick();
    tick();
    chk1("f_err_cleared", cnt_err, 1'b0);
    reset = 1'b0;
    tick();

    // Four requests: the fourth saturates at 3 and flags overflow.
    fetch_req_fire = 1'b1;
    tick();
    tick();
    tick();
    chk1("f_no_err_at_3", cnt_err, 1'b0);
    tick();
    fetch_req_fire = 1'b0;
    chk1("f_overflow_err", cnt_err, 1'b1);
    exc_oc = 1'b1;
    c = cyc;
    exp_flush.push_back(c + 1);
    tick();
    exc_oc = 1'b0;
    tick();
    fetch_resp_fire = 1'b1;
    exp_drop.push_back(c + 2);
    tick();
    exp_drop.push_back(c + 3);
    tick();
    exp_drop.push_back(c + 4);
    exp_redir.push_back('{c + 5, EXC_VEC});
    tick();
    fetch_resp_fire = 1'b0;
    handshake();

    // Reset while draining: back to IDLE, error cleared, no redirect afterwards.
    tick();
    fetch_req_fire = 1'b1;
    tick();
    fetch_req_fire = 1'b0;
    tick();
    exc_oc = 1'b1;
    c = cyc;
    exp_flush.push_back(c + 1);
    tick();
    exc_oc = 1'b0;
    tick();
    chk1("g_drain_busy", busy, 1'b1);
    chk1("g_drain_hold", fetch_hold, 1'b1);
    reset = 1'b1;
    tick();
    chk1("g_rst_busy", busy, 1'b0);
    chk1("g_rst_hold", fetch_hold, 1'b0);
    chk1("g_rst_flush", flush, 1'b0);
    chk1("g_rst_rv", redirect_valid, 1'b0);
    chk1("g_rst_err", cnt_err, 1'b0);
    reset = 1'b0;
    repeat (4) tick();
    chk1("g_no_redirect", redirect_valid, 1'b0);
    chk1("g_idle", busy, 1'b0);

    chk32("left_flush", 32'(exp_flush.size()), 32'h0);
    chk32("left_drop", 32'(exp_drop.size()), 32'h0);
    chk32("left_redirect", 32'(exp_redir.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
